// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states and
// the {Q[0], q_1} recode pair values.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One combinational Booth step: recode {Q[0],q_1}, add/sub M into A,
// then arithmetic right shift of {A,Q,q_1} by one.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], q1_i})
      BOOTH_ADD:  sum = a_i + m_i;
      BOOTH_SUB:  sum = a_i - m_i;
      BOOTH_NOP0,
      BOOTH_NOP1: sum = a_i;
      default:    sum = a_i;
    endcase
  end

  // The sign bit of the (WIDTH+1)-bit accumulator is replicated on shift.
  assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o  = {sum[0], q_i[WIDTH-1:1]};
  assign q1_o = q_i[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier: one recode/add/shift step per clock,
// valid/ready on both sides, abort flushes to IDLE.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [WIDTH:0]   m_q, m_d;

  logic [WIDTH:0]   step_a;
  logic [WIDTH-1:0] step_q;
  logic             step_q1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (step_a),
    .q_o  (step_q),
    .q1_o (step_q1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {in_a[WIDTH-1], in_a};
          q_d     = in_b;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides everything, including a same-edge accept or delivery.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  // A[WIDTH] duplicates A[WIDTH-1] once all steps are done; output is zero outside DONE.
  assign out_p     = out_valid ? {a_q[WIDTH-1:0], q_q} : '0;

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Multi-cycle radix-2 Booth multiplier for signed two's-complement operands.
- Retires one Booth recode/add/shift step per clock, so one adder is reused across WIDTH cycles instead of unrolling WIDTH adders combinationally.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Includes the FSM and step counter that sequence the shared step datapath.

Parameters:
- WIDTH, 6, operand width in bits. Must be >= 2. Product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), step-counter width. Derived; never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- abort  input  1  synchronous flush to IDLE. Highest priority.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  multiplicand, signed.
- in_b  input  WIDTH  multiplier, signed.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  2*WIDTH  signed product a*b.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, A=0, Q=0, q_1=0, M=0.
  - in_ready=1, out_valid=0, busy=0, out_p=0.
- Registers:
  - A: accumulator, WIDTH+1 bits. The extra bit is required so M = -2^(WIDTH-1) subtracts correctly.
  - Q: multiplier shift register, WIDTH bits.
  - q_1: Booth guard bit, 1 bit.
  - M: multiplicand, sign-extended to WIDTH+1 bits.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: M<=sext(in_a), Q<=in_b, A<=0, q_1<=0, cnt<=0, state<=CALC.
- State CALC (in_ready=0, out_valid=0):
  - Each edge performs one step on {Q[0],q_1}:
    - 01: A'=A+M.
    - 10: A'=A-M.
    - 00/11: A'=A.
  - Then arithmetic right shift of {A',Q,q_1} by one, replicating A'[WIDTH].
  - All arithmetic is WIDTH+1 bits modulo 2^(WIDTH+1).
  - cnt increments each step. When cnt==WIDTH-1 at an edge, that step completes and state<=DONE.
  - Exactly WIDTH steps are performed.
- State DONE:
  - out_valid=1.
  - out_p={A[WIDTH-1:0],Q}. A[WIDTH] equals A[WIDTH-1] here, so it is dropped.
  - out_p holds stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: state<=IDLE. No same-edge accept of a new operand; in_ready rises the next cycle.
- Latency and throughput:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Throughput is one product per WIDTH+2 cycles minimum.
- abort, sampled at an edge in any state:
  - state<=IDLE, cnt<=0. Datapath registers are don't-care.
  - The pending product is discarded; out_valid falls the next cycle.
  - abort and in_valid at the same edge in IDLE: abort wins and the operands are not accepted.
  - abort and out_ready at the same edge in DONE: the product counts as delivered; state still goes to IDLE.
- rst_n mid-CALC: immediate return to the reset values. No partial result is visible.
- Operands are captured at accept; in_a/in_b may change freely afterward.
- Outputs in_ready, out_valid and busy are decoded from state only (Moore). There is no combinational path from in_valid or out_ready to any output.
- FSM encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10. 2'b11 is illegal and recovers to IDLE at the next edge.

Decomposition:
- Package booth_pkg: state enum (IDLE, CALC, DONE) and Booth pair code constants (BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11).
- Sub-module booth_step (combinational, parameter WIDTH):
  - Inputs A, Q, q_1, M. Outputs next A, Q, q_1 after add/sub plus arithmetic shift.
  - booth_seq_mult instantiates it once and owns the FSM, counter and handshake.

Test Plan:
1. in_a=3, in_b=5, out_ready=1 -> out_valid 6 edges after accept, out_p=12'h00F, back in IDLE next cycle.
2. in_a=-3 (6'h3D), in_b=5 -> out_p=12'hFF1. Also in_a=31, in_b=-32 -> out_p=12'hC20.
3. in_a=-32, in_b=-32 -> out_p=12'h400. Checks the most-negative multiplicand via the WIDTH+1 accumulator.
4. out_ready held 0 for 10 cycles in DONE -> out_valid stays 1 and out_p stable, in_ready stays 0. Release out_ready -> one transfer, then in_ready=1.
5. abort pulsed at CALC step 3 -> next cycle state IDLE, in_ready=1, out_valid never asserted. A new 7*(-1) completes with out_p=12'hFF9.
6. rst_n asserted mid-CALC, asynchronously between edges -> outputs take reset values immediately. Back-to-back random signed pairs (1000 vectors) checked against a*b.
